// File: rtl/axi_channel_pkg.sv
// Register map, bit positions, response codes and FSM encodings for axi_channel_regs.
// No logic here; latency and backpressure are defined by the modules that import it.
package axi_channel_pkg;

    localparam logic [3:0] OFF_CONTROL  = 4'h0;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_DMA_ADDR = 4'h8;
    localparam logic [3:0] OFF_IRQ_EN   = 4'hC;

    typedef enum logic [1:0] {
        SEL_CONTROL  = OFF_CONTROL[3:2],
        SEL_STATUS   = OFF_STATUS[3:2],
        SEL_DMA_ADDR = OFF_DMA_ADDR[3:2],
        SEL_IRQ_EN   = OFF_IRQ_EN[3:2]
    } reg_sel_e;

    localparam int CTRL_RESET_BIT  = 0;
    localparam int CTRL_START_BIT  = 1;
    localparam int STAT_ACTIVE_BIT = 1;
    localparam int STAT_DONE_BIT   = 2;
    localparam int STAT_ERR_BIT    = 3;
    localparam int IRQ_DONE_BIT    = 0;
    localparam int IRQ_ERR_BIT     = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_RESP, RD_RECOVER} rd_state_e;
    typedef enum logic [2:0] {WR_IDLE, WR_AW, WR_W, WR_COMMIT, WR_RESP} wr_state_e;

    // Word index within a channel window; byte-offset bits [1:0] never reach here.
    function automatic reg_sel_e reg_sel(input logic [1:0] word_idx);
        return reg_sel_e'(word_idx);
    endfunction

endpackage

// File: rtl/axi_channel_regs_slice.sv
// One channel's CONTROL/STATUS/DMA_ADDR/IRQ_EN storage with start/reset strobes and W1C flags.
// Latency: writes land on the edge wr_en is high, strobes last one cycle; reads are combinational; no backpressure.
module axi_channel_regs_slice
    import axi_channel_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        wr_en,
    input  reg_sel_e    wr_sel,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  reg_sel_e    rd_sel,
    output logic [31:0] rd_data,
    input  logic        ch_active,
    output logic [7:0]  ch_address,
    output logic [7:0]  ch_command,
    output logic [7:0]  ch_count,
    output logic        ch_start,
    output logic        ch_reset,
    output logic [31:0] dma_addr,
    output logic        irq_req
);

    logic       wr_ctrl, wr_stat, wr_dma, wr_irqen;
    logic       start_req, start_err_set, done_set, w1c_done, w1c_err;
    logic       act_q, done_q, err_q;
    logic [1:0] irq_en_q;

    assign wr_ctrl  = wr_en && (wr_sel == SEL_CONTROL);
    assign wr_stat  = wr_en && (wr_sel == SEL_STATUS);
    assign wr_dma   = wr_en && (wr_sel == SEL_DMA_ADDR);
    assign wr_irqen = wr_en && (wr_sel == SEL_IRQ_EN);

    // A start is refused while the engine is busy or a strobe is still in flight.
    assign start_req     = wr_ctrl && wr_strb[0] && wr_data[CTRL_START_BIT];
    assign start_err_set = start_req && (ch_active || ch_start);
    assign done_set      = act_q && !ch_active;
    assign w1c_done      = wr_stat && wr_strb[0] && wr_data[STAT_DONE_BIT];
    assign w1c_err       = wr_stat && wr_strb[0] && wr_data[STAT_ERR_BIT];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ch_address <= '0;
            ch_command <= '0;
            ch_count   <= '0;
            ch_start   <= 1'b0;
            ch_reset   <= 1'b1;
            dma_addr   <= '0;
            irq_en_q   <= '0;
            act_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (wr_ctrl && wr_strb[3]) ch_address <= wr_data[31:24];
            if (wr_ctrl && wr_strb[2]) ch_command <= wr_data[23:16];
            if (wr_ctrl && wr_strb[1]) ch_count   <= wr_data[15:8];
            ch_start <= start_req && !start_err_set;
            ch_reset <= wr_ctrl && wr_strb[0] && wr_data[CTRL_RESET_BIT];
            for (int b = 0; b < 4; b++) begin
                if (wr_dma && wr_strb[b]) dma_addr[8*b +: 8] <= wr_data[8*b +: 8];
            end
            if (wr_irqen && wr_strb[0]) begin
                irq_en_q[IRQ_DONE_BIT] <= wr_data[IRQ_DONE_BIT];
                irq_en_q[IRQ_ERR_BIT]  <= wr_data[IRQ_ERR_BIT];
            end
            act_q  <= ch_active;
            // Hardware set beats a simultaneous write-one-to-clear.
            done_q <= done_set || (done_q && !w1c_done);
            err_q  <= start_err_set || (err_q && !w1c_err);
        end
    end

    assign irq_req = (done_q && irq_en_q[IRQ_DONE_BIT]) || (err_q && irq_en_q[IRQ_ERR_BIT]);

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_CONTROL: begin
                rd_data[31:8]           = {ch_address, ch_command, ch_count};
                rd_data[CTRL_START_BIT] = ch_start || ch_active;
            end
            SEL_STATUS: begin
                rd_data[STAT_ACTIVE_BIT] = ch_active;
                rd_data[STAT_DONE_BIT]   = done_q;
                rd_data[STAT_ERR_BIT]    = err_q;
            end
            SEL_DMA_ADDR: rd_data = dma_addr;
            SEL_IRQ_EN:   rd_data[1:0] = irq_en_q;
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: rtl/axi_channel_regs.sv
// AXI4-Lite slave fronting NUM_CHANNELS channel register slices, with registered irq.
// Latency: rvalid 1 cycle after AR, bvalid 2 cycles after last of AW/W; one outstanding read and write, ready held low until response retires.
module axi_channel_regs
    import axi_channel_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [31:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [31:0]               s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [8*NUM_CHANNELS-1:0] ch_address,
    output logic [8*NUM_CHANNELS-1:0] ch_command,
    output logic [8*NUM_CHANNELS-1:0] ch_count,
    output logic [NUM_CHANNELS-1:0]   ch_start,
    output logic [NUM_CHANNELS-1:0]   ch_reset,
    input  logic [NUM_CHANNELS-1:0]   ch_active,
    output logic [32*NUM_CHANNELS-1:0] dma_addr,
    output logic                      irq
);

    localparam int IDX_W = ADDR_WIDTH - 4;

    rd_state_e               rd_state, rd_next;
    wr_state_e               wr_state, wr_next;
    logic                    ar_hs, aw_hs, w_hs, wr_commit;
    logic [ADDR_WIDTH-1:2]   awaddr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic                    rd_ok, wr_ok;
    logic [31:0]             rd_mux;
    logic [31:0]             slice_rdata [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] slice_irq;
    logic                    unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_araddr[1:0], s_axi_awaddr[1:0]};
    assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:4];
    assign wr_idx = awaddr_q[ADDR_WIDTH-1:4];
    assign rd_ok  = 32'(rd_idx) < NUM_CHANNELS;
    assign wr_ok  = 32'(wr_idx) < NUM_CHANNELS;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;

    always_ff @(posedge aclk) begin
        if (!aresetn) rd_state <= RD_IDLE;
        else          rd_state <= rd_next;
    end

    // RECOVER holds arready low for one extra cycle after the R beat retires.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (s_axi_arvalid) rd_next = RD_RESP;
            RD_RESP: if (s_axi_rready)  rd_next = RD_RECOVER;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (rd_state == RD_IDLE);
        s_axi_rvalid  = (rd_state == RD_RESP);
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (32'(rd_idx) == i) rd_mux = slice_rdata[i];
        end
    end

    // Captured at accept time, so a same-cycle write is not yet visible.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rdata <= rd_ok ? rd_mux : 32'h0;
            s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) wr_state <= WR_IDLE;
        else          wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_next = WR_COMMIT;
                else if (aw_hs)    wr_next = WR_AW;
                else if (w_hs)     wr_next = WR_W;
            end
            WR_AW:     if (w_hs)  wr_next = WR_COMMIT;
            WR_W:      if (aw_hs) wr_next = WR_COMMIT;
            WR_COMMIT: wr_next = WR_RESP;
            default:   if (s_axi_bready) wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (wr_state == WR_IDLE) || (wr_state == WR_W);
        s_axi_wready  = (wr_state == WR_IDLE) || (wr_state == WR_AW);
        s_axi_bvalid  = (wr_state == WR_RESP);
        wr_commit     = (wr_state == WR_COMMIT);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_bresp <= RESP_OKAY;
            irq         <= 1'b0;
        end else begin
            if (aw_hs) awaddr_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (wr_commit) s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            irq <= |slice_irq;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        axi_channel_regs_slice u_slice (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .wr_en      (wr_commit && wr_ok && (32'(wr_idx) == g)),
            .wr_sel     (reg_sel(awaddr_q[3:2])),
            .wr_data    (wdata_q),
            .wr_strb    (wstrb_q),
            .rd_sel     (reg_sel(s_axi_araddr[3:2])),
            .rd_data    (slice_rdata[g]),
            .ch_active  (ch_active[g]),
            .ch_address (ch_address[8*g +: 8]),
            .ch_command (ch_command[8*g +: 8]),
            .ch_count   (ch_count[8*g +: 8]),
            .ch_start   (ch_start[g]),
            .ch_reset   (ch_reset[g]),
            .dma_addr   (dma_addr[32*g +: 32]),
            .irq_req    (slice_irq[g])
        );
    end

endmodule

// File: tb/tb_axi_channel_regs.sv
// Scoreboarded bench for axi_channel_regs: responses queued at issue, compared as R/B beats retire.
// Strobes and irq are checked directly against bench-computed values.
module tb_axi_channel_regs;
    import axi_channel_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_axi_araddr, s_axi_awaddr;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata, s_axi_wdata;
    logic [1:0]  s_axi_rresp, s_axi_bresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic        s_axi_awvalid, s_axi_awready;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready;
    logic [15:0] ch_address, ch_command, ch_count;
    logic [1:0]  ch_start, ch_reset, ch_active;
    logic [63:0] dma_addr;
    logic        irq;

    int          vectors = 0;
    int          miscompares = 0;
    int          r_done = 0;
    int          b_done = 0;
    int          start_cnt [2];
    int          rst_cnt [2];
    int          s0, s1, r0;
    rd_exp_t     exp_r [$];
    logic [1:0]  exp_b [$];
    rd_exp_t     r_e;
    logic [1:0]  b_e;

    always #5 aclk = ~aclk;

    axi_channel_regs #(.NUM_CHANNELS(2), .ADDR_WIDTH(8)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .ch_address    (ch_address),
        .ch_command    (ch_command),
        .ch_count      (ch_count),
        .ch_start      (ch_start),
        .ch_reset      (ch_reset),
        .ch_active     (ch_active),
        .dma_addr      (dma_addr),
        .irq           (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            for (int i = 0; i < 2; i++) begin
                start_cnt[i] += int'(ch_start[i]);
                rst_cnt[i]   += int'(ch_reset[i]);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    check_eq("rd_unexpected", {31'b0, s_axi_rvalid}, 32'h0);
                end else begin
                    r_e = exp_r.pop_front();
                    check_eq("rdata", s_axi_rdata, r_e.data);
                    check_eq("rresp", {30'b0, s_axi_rresp}, {30'b0, r_e.resp});
                    r_done++;
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) begin
                    check_eq("b_unexpected", {31'b0, s_axi_bvalid}, 32'h0);
                end else begin
                    b_e = exp_b.pop_front();
                    check_eq("bresp", {30'b0, s_axi_bresp}, {30'b0, b_e});
                    b_done++;
                end
            end
        end
    end

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        int   target;
        logic aw_ok, w_ok;
        exp_b.push_back(resp);
        target = b_done + 1;
        @(negedge aclk);
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        for (int n = 0; n < 50 && (s_axi_awvalid || s_axi_wvalid); n++) begin
            aw_ok = s_axi_awvalid && s_axi_awready;
            w_ok  = s_axi_wvalid && s_axi_wready;
            @(negedge aclk);
            if (aw_ok) s_axi_awvalid = 1'b0;
            if (w_ok)  s_axi_wvalid  = 1'b0;
        end
        if (s_axi_awvalid || s_axi_wvalid) begin
            check_eq("aw_w_accept", {30'b0, s_axi_awvalid, s_axi_wvalid}, 32'h0);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
        end
        for (int n = 0; n < 50 && b_done < target; n++) @(negedge aclk);
        check_eq("b_done", b_done, target);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int      target;
        logic    ar_ok;
        rd_exp_t e;
        e.data = data;
        e.resp = resp;
        exp_r.push_back(e);
        target = r_done + 1;
        @(negedge aclk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        for (int n = 0; n < 50 && s_axi_arvalid; n++) begin
            ar_ok = s_axi_arready;
            @(negedge aclk);
            if (ar_ok) s_axi_arvalid = 1'b0;
        end
        if (s_axi_arvalid) begin
            check_eq("ar_accept", {31'b0, s_axi_arvalid}, 32'h0);
            s_axi_arvalid = 1'b0;
        end
        for (int n = 0; n < 150 && r_done < target; n++) @(negedge aclk);
        check_eq("r_done", r_done, target);
    endtask

    task automatic check_reset_state(input string phase);
        check_eq({phase, "_ch_reset"}, {30'b0, ch_reset}, 32'h3);
        check_eq({phase, "_ready"}, {29'b0, s_axi_arready, s_axi_awready, s_axi_wready}, 32'h7);
        check_eq({phase, "_valid_irq"}, {29'b0, s_axi_rvalid, s_axi_bvalid, irq}, 32'h0);
        check_eq({phase, "_ch_start"}, {30'b0, ch_start}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded, got %0d vectors", $time, vectors);
        $fatal(1);
    end

    initial begin
        start_cnt = '{0, 0};
        rst_cnt   = '{0, 0};
        aresetn = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata  = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        ch_active    = 2'b00;

        repeat (3) @(negedge aclk);
        check_reset_state("rst0");
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("rst0_release_ch_reset", {30'b0, ch_reset}, 32'h0);
        axi_read(8'h10, 32'h0, RESP_OKAY);
        axi_read(8'h08, 32'h0, RESP_OKAY);

        // Full CONTROL write on ch1 with start
        s0 = start_cnt[0]; s1 = start_cnt[1];
        axi_write(8'h10, 32'h1234_5602, 4'hF, RESP_OKAY);
        check_eq("ch1_address", {24'b0, ch_address[15:8]}, 32'h12);
        check_eq("ch1_command", {24'b0, ch_command[15:8]}, 32'h34);
        check_eq("ch1_count", {24'b0, ch_count[15:8]}, 32'h56);
        check_eq("ch1_start_pulses", start_cnt[1] - s1, 1);
        check_eq("ch0_start_pulses", start_cnt[0] - s0, 0);
        axi_read(8'h10, 32'h1234_5600, RESP_OKAY);

        // Byte-lane strobes on DMA_ADDR
        axi_write(8'h08, 32'hDEAD_BEEF, 4'b0101, RESP_OKAY);
        check_eq("ch0_dma_addr", dma_addr[31:0], 32'h00AD_00EF);
        axi_read(8'h08, 32'h00AD_00EF, RESP_OKAY);

        // Start while busy is refused and flagged
        @(negedge aclk);
        ch_active = 2'b01;
        s0 = start_cnt[0];
        axi_write(8'h00, 32'h0000_0002, 4'hF, RESP_OKAY);
        check_eq("busy_start_pulses", start_cnt[0] - s0, 0);
        axi_read(8'h04, 32'h0000_000A, RESP_OKAY);
        axi_read(8'h00, 32'h0000_0002, RESP_OKAY);

        // DONE on active falling edge drives irq one cycle later
        axi_write(8'h0C, 32'h0000_0001, 4'hF, RESP_OKAY);
        check_eq("irq_err_masked", {31'b0, irq}, 32'h0);
        @(negedge aclk);
        ch_active = 2'b00;
        @(negedge aclk);
        check_eq("irq_latency", {31'b0, irq}, 32'h0);
        @(negedge aclk);
        check_eq("irq_done_set", {31'b0, irq}, 32'h1);
        axi_read(8'h04, 32'h0000_000C, RESP_OKAY);
        axi_write(8'h04, 32'h0000_0004, 4'hF, RESP_OKAY);
        repeat (2) @(negedge aclk);
        check_eq("irq_after_w1c", {31'b0, irq}, 32'h0);
        axi_read(8'h04, 32'h0000_0008, RESP_OKAY);
        axi_write(8'h04, 32'h0000_0008, 4'hF, RESP_OKAY);
        axi_read(8'h04, 32'h0000_0000, RESP_OKAY);

        // Zero strobe: OKAY, nothing changes
        s1 = start_cnt[1]; r0 = rst_cnt[1];
        axi_write(8'h10, 32'hFFFF_FFFF, 4'h0, RESP_OKAY);
        check_eq("strb0_start", start_cnt[1] - s1, 0);
        check_eq("strb0_reset", rst_cnt[1] - r0, 0);
        axi_read(8'h10, 32'h1234_5600, RESP_OKAY);

        // Reset strobe via lane 0 only
        r0 = rst_cnt[0];
        axi_write(8'h00, 32'hFFFF_FF01, 4'h1, RESP_OKAY);
        check_eq("ch0_reset_pulses", rst_cnt[0] - r0, 1);
        axi_read(8'h00, 32'h0000_0000, RESP_OKAY);

        axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
        axi_read(8'h1C, 32'h0000_0003, RESP_OKAY);
        check_eq("irq_no_status", {31'b0, irq}, 32'h0);

        // Out-of-range channel
        s0 = start_cnt[0]; s1 = start_cnt[1];
        axi_write(8'h20, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
        axi_read(8'h20, 32'h0, RESP_SLVERR);
        axi_read(8'h2C, 32'h0, RESP_SLVERR);
        check_eq("oob_start", (start_cnt[0] - s0) + (start_cnt[1] - s1), 0);
        axi_read(8'h08, 32'h00AD_00EF, RESP_OKAY);
        axi_read(8'h10, 32'h1234_5600, RESP_OKAY);

        // Same-cycle read and write of one register sees the old value
        fork
            axi_write(8'h18, 32'hCAFE_F00D, 4'hF, RESP_OKAY);
            axi_read(8'h18, 32'h0000_0000, RESP_OKAY);
        join
        axi_read(8'h18, 32'hCAFE_F00D, RESP_OKAY);

        // R channel backpressure
        s_axi_rready = 1'b0;
        fork
            axi_read(8'h08, 32'h00AD_00EF, RESP_OKAY);
            begin
                repeat (4) @(negedge aclk);
                check_eq("rvalid_held", {31'b0, s_axi_rvalid}, 32'h1);
                check_eq("arready_busy", {31'b0, s_axi_arready}, 32'h0);
                s_axi_rready = 1'b1;
            end
        join

        // Reset with AW accepted but W outstanding
        @(negedge aclk);
        s_axi_awaddr  = 8'h08;
        s_axi_awvalid = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        check_eq("aw_held_awready", {31'b0, s_axi_awready}, 32'h0);
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_state("rst1");
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("rst1_release_ch_reset", {30'b0, ch_reset}, 32'h0);
        axi_read(8'h08, 32'h0, RESP_OKAY);
        axi_read(8'h10, 32'h0, RESP_OKAY);
        axi_read(8'h1C, 32'h0, RESP_OKAY);
        axi_write(8'h08, 32'h1122_3344, 4'hF, RESP_OKAY);
        axi_read(8'h08, 32'h1122_3344, RESP_OKAY);
        check_eq("ch0_dma_after_reset", dma_addr[31:0], 32'h1122_3344);

        repeat (3) @(negedge aclk);
        check_eq("rd_queue_empty", exp_r.size(), 0);
        check_eq("b_queue_empty", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
